// File: rtl/ppu_pkg.sv
// Shared constants for the PPU pipeline.
// Imported by the fetch front end and its IF/ID register.
package ppu_pkg;
  localparam int AW_DEF      = 8;
  localparam int DW_DEF      = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between fetch and imem.
// Address out, combinational instruction word back.
interface fetch_stage_if #(
  parameter int AW = 8,
  parameter int DW = 32
);
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_data;

  modport master (
    output imem_addr,
    input  imem_data
  );

  modport slave (
    input  imem_addr,
    output imem_data
  );
endinterface

// File: rtl/if_id_register.sv
// IF/ID pipeline register: instruction, its PC, valid.
// Flush loads a bubble; le=0 holds everything.
module if_id_register
  import ppu_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          le,
  input  logic          flush,
  input  logic [DW-1:0] instr_in,
  input  logic [AW-1:0] pc_in,
  output logic [DW-1:0] instr,
  output logic [AW-1:0] pc,
  output logic          valid
);

  logic [DW-1:0] instr_d, instr_q;
  logic [AW-1:0] pc_d, pc_q;
  logic          valid_d, valid_q;

  // Next IF/ID contents: hold on stall, bubble on flush.
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (le) begin
      pc_d = pc_in;
      if (flush) begin
        instr_d = DW'(NOP_INSTR);
        valid_d = 1'b0;
      end else begin
        instr_d = instr_in;
        valid_d = 1'b1;
      end
    end
  end

  // IF/ID state with synchronous reset to an empty bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign instr = instr_q;
  assign pc    = pc_q;
  assign valid = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Fetch front end: PC/nPC pair, imem addressing,
// delayed-branch redirect, flush and fetch counter.
module fetch_stage
  import ppu_pkg::*;
#(
  parameter int            AW       = AW_DEF,
  parameter int            DW       = DW_DEF,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          le,
  input  logic          br_taken,
  input  logic [AW-1:0] br_target,
  input  logic          nullify,
  fetch_stage_if.master imem,
  output logic [AW-1:0] pc_out,
  output logic [AW-1:0] npc_out,
  output logic [DW-1:0] ifid_instr,
  output logic [AW-1:0] ifid_pc,
  output logic          ifid_valid,
  output logic [15:0]   fetch_count
);

  localparam logic [AW-1:0] STEP = AW'(INSTR_BYTES);

  logic [AW-1:0] pc_d, pc_q;
  logic [AW-1:0] npc_d, npc_q;
  logic [AW-1:0] tgt;
  logic [15:0]   cnt_d, cnt_q;

  assign tgt = {br_target[AW-1:2], 2'b00};

  // Next PC/nPC: sequential step or delayed-branch redirect.
  always_comb begin
    pc_d  = pc_q;
    npc_d = npc_q;
    if (le) begin
      if (br_taken) begin
        pc_d  = tgt;
        npc_d = tgt + STEP;
      end else begin
        pc_d  = npc_q;
        npc_d = npc_q + STEP;
      end
    end
  end

  // Count valid captures, sticking at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (le && !nullify && cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // PC/nPC and counter state with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= RESET_PC;
      npc_q <= RESET_PC + STEP;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      npc_q <= npc_d;
      cnt_q <= cnt_d;
    end
  end

  if_id_register #(
    .AW (AW),
    .DW (DW)
  ) u_if_id (
    .clk      (clk),
    .reset    (reset),
    .le       (le),
    .flush    (nullify),
    .instr_in (imem.imem_data),
    .pc_in    (pc_q),
    .instr    (ifid_instr),
    .pc       (ifid_pc),
    .valid    (ifid_valid)
  );

  assign imem.imem_addr = pc_q;
  assign pc_out         = pc_q;
  assign npc_out        = npc_q;
  assign fetch_count    = cnt_q;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch front end of the PA-RISC PPU pipeline.
- Owns the PC/nPC register pair and drives the 8-bit byte address into the instruction memory.
- Captures the 32-bit big-endian instruction returned combinationally in the same cycle into the IF/ID pipeline register.
- Handles load-enable stalls, redirect of a taken branch resolved in ID, and nullification (flush) of the fetched instruction.

Parameters:
- AW, 8, byte-address width; PC arithmetic is modulo 2^AW.
- DW, 32, instruction width.
- RESET_PC, 0, PC value loaded on reset; must be a multiple of 4.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- le  in  1  load enable; 0 = stall, and all state holds.
- br_taken  in  1  taken branch/jump resolved in ID this cycle.
- br_target  in  AW  branch target byte address; bits [1:0] ignored (forced to 0).
- nullify  in  1  flush: the instruction fetched this cycle enters IF/ID as a bubble.
- imem_addr  out  AW  address to instruction memory; equals pc.
- imem_data  in  DW  instruction from instruction memory, valid combinationally for imem_addr.
- pc_out  out  AW  current PC.
- npc_out  out  AW  current nPC.
- ifid_instr  out  DW  IF/ID instruction register.
- ifid_pc  out  AW  address of ifid_instr.
- ifid_valid  out  1  1 = ifid_instr is a real instruction, 0 = bubble.
- fetch_count  out  16  number of valid instructions captured into IF/ID; saturates at 16'hFFFF.

Behaviour:
- Reset (reset=1 at posedge; overrides all other inputs, including mid-stall or mid-branch):
  - pc=RESET_PC, npc=RESET_PC+4.
  - ifid_instr=0, ifid_pc=0, ifid_valid=0, fetch_count=0.
- imem_addr, pc_out and npc_out are driven directly from registers; there is no combinational path from any input to them.
- Latency: the instruction at address A appears on ifid_instr one cycle after pc=A with le=1.
- Normal cycle (le=1, br_taken=0):
  - ifid_instr<=imem_data, ifid_pc<=pc.
  - pc<=npc, npc<=npc+4.
- Taken branch (le=1, br_taken=1):
  - The instruction currently at pc is the delay slot and is captured into IF/ID normally.
  - pc<={br_target[AW-1:2],2'b00}, npc<=that value+4.
- Nullify (le=1, nullify=1):
  - ifid_instr<=0, ifid_valid<=0, ifid_pc<=pc.
  - PC update proceeds as above. Combined with br_taken, this kills the delay slot while still redirecting.
- Valid flag: ifid_valid<=1 on any le=1 cycle without nullify.
- fetch_count increments on every cycle that loads ifid_valid=1 and saturates at 16'hFFFF.
- Stall (le=0):
  - pc, npc, all IF/ID registers and fetch_count hold.
  - br_taken and nullify are ignored; ID must hold and re-assert them.
- Wrap-around: npc+4 and target+4 wrap modulo 256 (for example, 8'hFC+4=8'h00) with no error flag.
- Priority: reset > le=0 > nullify for the IF/ID contents; br_taken controls only the PC/nPC path.

Decomposition:
- Shared package ppu_pkg:
  - INSTR_BYTES=4.
  - NOP_INSTR=32'h0000_0000.
  - AW/DW defaults.
- One sub-module, if_id_register: holds ifid_instr, ifid_pc and ifid_valid, with le, flush and reset inputs.
- PC/nPC logic and the counter stay in fetch_stage.

Test Plan:
- Reset then 4 cycles with le=1, memory words 0x11111111, 0x22222222, 0x33333333, 0x44444444 at 0, 4, 8, 12:
  - pc goes 0→4→8→12→16.
  - ifid_instr goes 0x11111111 … 0x44444444 with ifid_pc 0, 4, 8, 12.
  - fetch_count=4.
- Stall: le=0 for 3 cycles at pc=8.
  - pc, npc, ifid_* and fetch_count are unchanged.
  - On the first le=1 cycle, ifid_instr=0x33333333.
- Branch with br_taken=1, br_target=8'h43 while pc=12:
  - 0x44444444 (delay slot) is captured.
  - Next pc=8'h40, npc=8'h44.
- Branch with nullify=1 on the same cycle as the previous case:
  - ifid_valid=0, ifid_instr=0, fetch_count not incremented.
  - pc=8'h40.
- Wrap: pc=8'hF8, run 3 cycles.
  - pc goes F8→FC→00→04 with no glitch on ifid_pc.
- Reset asserted mid-stall with br_taken=1:
  - Next cycle pc=RESET_PC, npc=RESET_PC+4, ifid_valid=0, fetch_count=0.
